// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a valid/ready request
// port with a fixed access latency. Byte addresses come in on addr; accesses
// that are not word-aligned are answered with resp_err and have no effect.
// Optional build macro DMEM_BYTE_STROBE_EN adds the per-byte store enable
// port be; without it every store writes the full word.
module dmem_responder #(
  parameter int n       = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           memwrite,
  input  logic [n-1:0]   addr,
  input  logic [n-1:0]   writedata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [n/8-1:0] be,
`endif
  output logic [n-1:0]   readdata,
  output logic           resp_valid,
  output logic           resp_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NB  = n / 8;
  localparam int WCW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [WCW-1:0] WCNT_INIT = (LATENCY >= 2) ? WCW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, nstate;
  logic [WCW-1:0] wcnt;
  logic [AW+1:0]  addr_q;
  logic [n-1:0]   wdata_q;
  logic           we_q;
  logic           accept, enter_resp, commit;
  logic [AW+1:0]  eff_addr;
  logic [n-1:0]   eff_wdata;
  logic           eff_we;
  logic [AW-1:0]  idx;
  logic           misaligned;
  logic [n-1:0]   wmask, merged;
  logic [n-1:0]   mem [DEPTH];

  // Only the low address bits select a word; the rest wrap.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 RESP is entered on the accept edge itself, so the live
  // port values are used while idle and the latched copy afterwards.
  assign eff_addr   = (state == IDLE) ? addr[AW+1:0] : addr_q;
  assign eff_wdata  = (state == IDLE) ? writedata    : wdata_q;
  assign eff_we     = (state == IDLE) ? memwrite     : we_q;
  assign idx        = eff_addr[AW+1:2];
  assign misaligned = |eff_addr[1:0];

`ifdef DMEM_BYTE_STROBE_EN
  logic [NB-1:0] be_q, eff_be;
  assign eff_be = (state == IDLE) ? be : be_q;

  // Expand byte enables into a bit mask for the read-modify-write merge.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++) wmask[i*8 +: 8] = {8{eff_be[i]}};
  end

  // Byte-enable capture on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      be_q <= '0;
    else if (accept) be_q <= be;
  end
`else
  assign wmask = '1;
`endif

  assign merged = (mem[idx] & ~wmask) | (eff_wdata & wmask);
  assign commit = enter_resp && eff_we && !misaligned;

  // Next-state logic; enter_resp marks the edge that produces the response.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (wcnt == '0) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
    enter_resp = (nstate == RESP) && (state != RESP);
  end

  // State register and wait-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && accept)          wcnt <= WCNT_INIT;
      else if (state == WAIT && wcnt != '0) wcnt <= wcnt - 1'b1;
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr[AW+1:0];
      wdata_q <= writedata;
      we_q    <= memwrite;
    end
  end

  // Response registers: one-cycle strobe, write-first data, error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      resp_err   <= enter_resp && misaligned;
      if (enter_resp) readdata <= misaligned ? '0 : (eff_we ? merged : mem[idx]);
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= merged;
  end

endmodule
